hier_fanout_node: RTL and testbench

Parametrised hierarchy node that distributes commands from one parent to NUM_CHILD child instances and returns one aggregated response per command. Each command is buffered in a DEPTH-entry FIFO and either broadcast to all enabled children or unicast round-robin to one child. Nodes cascade to build generated module trees of arbitrary fan-out. A node's up_* side connects to the parent's dn_* slice.

---
 rtl/hier_fanout_node_if.sv | 29 ++
 rtl/hier_fanout_node.sv | 160 ++++++++++++++++
 tb/tb_hier_fanout_node.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hier_fanout_node_if.sv
// Command/response link around one hierarchy node: up_* faces the parent, dn_* fans out
// to the children (a child node's up_* side attaches to one slice of its parent's dn_*).
interface hier_fanout_node_if #(
   parameter int unsigned NUM_CHILD = 5,
   parameter int unsigned DATA_W    = 16
);
   logic                 up_cmd_valid;
   logic                 up_cmd_ready;
   logic [DATA_W-1:0]    up_cmd_data;
   logic                 up_rsp_valid;
   logic                 up_rsp_ready;
   logic                 up_rsp_err;
   logic [NUM_CHILD-1:0] up_rsp_mask;
   logic [NUM_CHILD-1:0] dn_cmd_valid;
   logic [NUM_CHILD-1:0] dn_cmd_ready;
   logic [DATA_W-1:0]    dn_cmd_data;
   logic [NUM_CHILD-1:0] dn_rsp_valid;
   logic [NUM_CHILD-1:0] dn_rsp_err;

   // master: the parent plus children surrounding a node; slave: the node itself
   modport master (
      output up_cmd_valid, up_cmd_data, up_rsp_ready, dn_cmd_ready, dn_rsp_valid, dn_rsp_err,
      input  up_cmd_ready, up_rsp_valid, up_rsp_err, up_rsp_mask, dn_cmd_valid, dn_cmd_data
   );
   modport slave (
      input  up_cmd_valid, up_cmd_data, up_rsp_ready, dn_cmd_ready, dn_rsp_valid, dn_rsp_err,
      output up_cmd_ready, up_rsp_valid, up_rsp_err, up_rsp_mask, dn_cmd_valid, dn_cmd_data
   );
endinterface

// File: rtl/hier_fanout_node.sv
// Hierarchy fan-out node: FIFOs parent commands, issues each to all enabled children
// (MODE 0) or to one child round-robin (MODE 1), and returns one aggregated response.
module hier_fanout_node #(
   parameter int unsigned NUM_CHILD = 5,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MODE      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   hier_fanout_node_if.slave            bus,
   input  logic [NUM_CHILD-1:0]         child_en,
   output logic [$clog2(DEPTH+1)-1:0]   cmd_level,
   output logic                         busy
);
   localparam int unsigned LvlW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned IdxW = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]      level_q, level_d;
   logic                 push, pop;

   logic [1:0]           state_q, state_d;
   logic [DATA_W-1:0]    cmd_q, cmd_d;
   logic [NUM_CHILD-1:0] tgt_q, tgt_d, acc_q, acc_d, done_q, done_d;
   logic                 err_q, err_d;
   logic [IdxW-1:0]      rr_q, rr_d, rr_next;
   logic [NUM_CHILD-1:0] rr_tgt, new_tgt, hs, new_done;
   logic                 rr_found;
   int unsigned          rr_idx;

   // Ready depends only on occupancy, never on a same-cycle pop.
   assign bus.up_cmd_ready = (level_q < LvlW'(DEPTH));
   assign push             = bus.up_cmd_valid & bus.up_cmd_ready;
   assign pop              = (state_q == StIdle) && (level_q != '0);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LvlW'(1);
         2'b01:   level_d = level_q - LvlW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.up_cmd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         level_q <= level_d;
      end
   end

   // First enabled child at or after the pointer, wrapping once around the ring.
   always_comb begin
      rr_tgt   = '0;
      rr_next  = rr_q;
      rr_found = 1'b0;
      rr_idx   = 0;
      for (int unsigned k = 0; k < NUM_CHILD; k++) begin
         rr_idx = 32'(rr_q) + k;
         if (rr_idx >= NUM_CHILD) rr_idx = rr_idx - NUM_CHILD;
         if (!rr_found && child_en[rr_idx[IdxW-1:0]]) begin
            rr_found                  = 1'b1;
            rr_tgt[rr_idx[IdxW-1:0]]  = 1'b1;
            rr_next = (rr_idx == NUM_CHILD - 1) ? '0 : IdxW'(rr_idx + 1);
         end
      end
   end

   assign new_tgt  = (MODE == 0) ? child_en : rr_tgt;
   assign hs       = bus.dn_cmd_valid & bus.dn_cmd_ready;
   assign new_done = bus.dn_rsp_valid & tgt_q & ~done_q;

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      tgt_d   = tgt_q;
      acc_d   = acc_q;
      done_d  = done_q;
      err_d   = err_q;
      rr_d    = rr_q;
      case (state_q)
         StIdle: begin
            if (pop) begin
               cmd_d = mem_q[rd_ptr_q];
               tgt_d = new_tgt;
               if (MODE != 0) rr_d = rr_next;
               if (new_tgt != '0) begin
                  state_d = StIssue;
               end else begin
                  state_d = StResp;
                  err_d   = 1'b1;
               end
            end
         end
         StIssue, StWait: begin
            // Done pulses count from the first ISSUE cycle, even ahead of their accept.
            acc_d  = acc_q | hs;
            done_d = done_q | new_done;
            err_d  = err_q | (|(new_done & bus.dn_rsp_err));
            if (acc_d == tgt_q) begin
               state_d = (done_d == tgt_q) ? StResp : StWait;
            end
         end
         StResp: begin
            if (bus.up_rsp_ready) begin
               acc_d   = '0;
               done_d  = '0;
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cmd_q   <= '0;
         tgt_q   <= '0;
         acc_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         tgt_q   <= tgt_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rr_q    <= rr_d;
      end
   end

   assign bus.dn_cmd_valid = (state_q == StIssue) ? (tgt_q & ~acc_q) : '0;
   assign bus.dn_cmd_data  = cmd_q;
   assign bus.up_rsp_valid = (state_q == StResp);
   assign bus.up_rsp_err   = (state_q == StResp) & err_q;
   assign bus.up_rsp_mask  = (state_q == StResp) ? tgt_q : '0;
   assign cmd_level        = level_q;
   assign busy             = (state_q != StIdle) || (level_q != '0);
endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: a broadcast and a round-robin instance share stimulus;
// directed scenarios plus randomized commands checked against a transaction-level model.
module tb_hier_fanout_node;
   localparam int unsigned NC = 5;
   localparam int unsigned DW = 16;
   localparam int unsigned DP = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          up_cmd_valid, up_rsp_ready;
   logic [DW-1:0] up_cmd_data;
   logic [NC-1:0] dn_cmd_ready, dn_rsp_valid, dn_rsp_err, child_en;
   logic [2:0]    lvl0, lvl1;
   logic          busy0, busy1;
   logic          mode;
   int            n_cmp = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   hier_fanout_node_if #(.NUM_CHILD(NC), .DATA_W(DW)) if0 ();
   hier_fanout_node_if #(.NUM_CHILD(NC), .DATA_W(DW)) if1 ();

   assign if0.up_cmd_valid = up_cmd_valid;
   assign if0.up_cmd_data  = up_cmd_data;
   assign if0.up_rsp_ready = up_rsp_ready;
   assign if0.dn_cmd_ready = dn_cmd_ready;
   assign if0.dn_rsp_valid = dn_rsp_valid;
   assign if0.dn_rsp_err   = dn_rsp_err;
   assign if1.up_cmd_valid = up_cmd_valid;
   assign if1.up_cmd_data  = up_cmd_data;
   assign if1.up_rsp_ready = up_rsp_ready;
   assign if1.dn_cmd_ready = dn_cmd_ready;
   assign if1.dn_rsp_valid = dn_rsp_valid;
   assign if1.dn_rsp_err   = dn_rsp_err;

   hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .DEPTH(DP), .MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .child_en(child_en), .cmd_level(lvl0), .busy(busy0)
   );
   hier_fanout_node #(.NUM_CHILD(NC), .DATA_W(DW), .DEPTH(DP), .MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .child_en(child_en), .cmd_level(lvl1), .busy(busy1)
   );

   // Observed outputs of the instance under test.
   logic          o_ready, o_rvalid, o_rerr, o_busy;
   logic [NC-1:0] o_rmask, o_dvalid;
   logic [DW-1:0] o_ddata;
   logic [2:0]    o_lvl;
   assign o_ready  = mode ? if1.up_cmd_ready : if0.up_cmd_ready;
   assign o_rvalid = mode ? if1.up_rsp_valid : if0.up_rsp_valid;
   assign o_rerr   = mode ? if1.up_rsp_err   : if0.up_rsp_err;
   assign o_rmask  = mode ? if1.up_rsp_mask  : if0.up_rsp_mask;
   assign o_dvalid = mode ? if1.dn_cmd_valid : if0.dn_cmd_valid;
   assign o_ddata  = mode ? if1.dn_cmd_data  : if0.dn_cmd_data;
   assign o_lvl    = mode ? lvl1 : lvl0;
   assign o_busy   = mode ? busy1 : busy0;

   // Round-robin reference: first enabled child at index >= ptr, wrapping; -1 if none.
   function automatic int rr_pick(input logic [NC-1:0] en, input int ptr);
      for (int k = 0; k < NC; k++) begin
         if (en[(ptr + k) % NC]) return (ptr + k) % NC;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      up_cmd_valid = 1'b0; up_cmd_data = '0; up_rsp_ready = 1'b0;
      dn_cmd_ready = '0; dn_rsp_valid = '0; dn_rsp_err = '0; child_en = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      up_cmd_valid = 1'b1; up_cmd_data = 16'h5A5A; up_rsp_ready = 1'b0;
      dn_cmd_ready = '1; dn_rsp_valid = '0; dn_rsp_err = '0; child_en = '1;
      repeat (3) tick();
      n_cmp++;
      if ({if0.dn_cmd_valid, if0.up_rsp_valid, if0.up_rsp_err, if0.up_rsp_mask,
           if0.dn_cmd_data, lvl0, busy0} !== '0) begin
         n_fail++; $display("FAIL reset_outputs_mode0: got nonzero outputs, expected all 0");
      end
      n_cmp++;
      if ({if1.dn_cmd_valid, if1.up_rsp_valid, if1.up_rsp_err, if1.up_rsp_mask,
           if1.dn_cmd_data, lvl1, busy1} !== '0) begin
         n_fail++; $display("FAIL reset_outputs_mode1: got nonzero outputs, expected all 0");
      end
      up_cmd_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if ({if0.up_cmd_ready, if1.up_cmd_ready, busy0, busy1} !== 4'b1100) begin
         n_fail++;
         $display("FAIL reset_ready_busy: got %b expected 1100",
                  {if0.up_cmd_ready, if1.up_cmd_ready, busy0, busy1});
      end
   endtask

   task automatic test_broadcast();
      int ord [5] = '{4, 0, 2, 1, 3};
      do_reset(); mode = 1'b0;
      child_en = 5'h1F; dn_cmd_ready = 5'h1F;
      up_cmd_valid = 1'b1; up_cmd_data = 16'h1234;
      tick();
      up_cmd_valid = 1'b0;
      n_cmp++;
      if (o_dvalid !== 5'h00) begin
         n_fail++; $display("FAIL bcast_t1: dn_cmd_valid got %h expected 00", o_dvalid);
      end
      tick();
      n_cmp++;
      if ({o_dvalid, o_ddata} !== {5'h1F, 16'h1234}) begin
         n_fail++; $display("FAIL bcast_t2: valid/data got %h/%h expected 1f/1234", o_dvalid, o_ddata);
      end
      tick();
      n_cmp++;
      if (o_dvalid !== 5'h00) begin
         n_fail++; $display("FAIL bcast_t3: dn_cmd_valid got %h expected 00", o_dvalid);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (o_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL bcast_early_rsp: up_rsp_valid got 1 expected 0 (step %0d)", i);
         end
         dn_rsp_valid = 5'(1 << ord[i]);
         tick();
      end
      dn_rsp_valid = '0;
      n_cmp++;
      if ({o_rvalid, o_rerr, o_rmask} !== {1'b1, 1'b0, 5'h1F}) begin
         n_fail++;
         $display("FAIL bcast_rsp: valid/err/mask got %b/%b/%h expected 1/0/1f", o_rvalid, o_rerr, o_rmask);
      end
      up_rsp_ready = 1'b1;
      tick();
      up_rsp_ready = 1'b0;
      n_cmp++;
      if ({o_rvalid, o_busy} !== 2'b00) begin
         n_fail++; $display("FAIL bcast_after_hs: valid/busy got %b expected 00", {o_rvalid, o_busy});
      end
   endtask

   task automatic test_stall_dup();
      logic [NC-1:0] exp_v;
      do_reset(); mode = 1'b0;
      child_en = 5'h1F; dn_cmd_ready = 5'b10111;
      up_cmd_valid = 1'b1; up_cmd_data = 16'h00A5;
      tick();
      up_cmd_valid = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         exp_v = (c == 0) ? 5'h1F : 5'h08;
         n_cmp++;
         if (o_dvalid !== exp_v) begin
            n_fail++; $display("FAIL stall_valid_%0d: got %h expected %h", c, o_dvalid, exp_v);
         end
         dn_rsp_valid = (c == 0 || c == 2) ? 5'b00010 : 5'b00000;
         dn_rsp_err   = (c == 0) ? 5'b00010 : 5'b00000;
         tick();
      end
      dn_rsp_valid = '0; dn_rsp_err = '0;
      dn_cmd_ready = 5'h1F;
      n_cmp++;
      if (o_dvalid !== 5'h08) begin
         n_fail++; $display("FAIL stall_release: got %h expected 08", o_dvalid);
      end
      tick();
      n_cmp++;
      if (o_dvalid !== 5'h00) begin
         n_fail++; $display("FAIL stall_dropped: got %h expected 00", o_dvalid);
      end
      dn_rsp_valid = 5'h1F;
      tick();
      dn_rsp_valid = '0;
      for (int s = 0; s < 3; s++) begin
         n_cmp++;
         if ({o_rvalid, o_rerr, o_rmask} !== {1'b1, 1'b1, 5'h1F}) begin
            n_fail++;
            $display("FAIL stall_rsp_%0d: valid/err/mask got %b/%b/%h expected 1/1/1f",
                     s, o_rvalid, o_rerr, o_rmask);
         end
         if (s == 2) up_rsp_ready = 1'b1;
         tick();
      end
      up_rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      int ptr = 0;
      int pick, cyc;
      logic [NC-1:0] en = 5'b10110;
      do_reset(); mode = 1'b1;
      child_en = en; dn_cmd_ready = 5'h1F; dn_rsp_valid = 5'h1F;
      for (int k = 0; k < 4; k++) begin
         up_cmd_valid = 1'b1; up_cmd_data = 16'(16'hA000 + k);
         tick();
      end
      up_cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pick = rr_pick(en, ptr);
         ptr  = (pick + 1) % NC;
         cyc  = 0;
         while (!o_rvalid && cyc < 40) begin
            if (o_dvalid != '0) begin
               n_cmp++;
               if ({o_dvalid, o_ddata} !== {5'(1 << pick), 16'(16'hA000 + k)}) begin
                  n_fail++;
                  $display("FAIL rr_issue_%0d: valid/data got %h/%h expected %h/%h", k,
                           o_dvalid, o_ddata, 5'(1 << pick), 16'(16'hA000 + k));
               end
            end
            tick(); cyc++;
         end
         n_cmp++;
         if ({o_rvalid, o_rerr, o_rmask} !== {1'b1, 1'b0, 5'(1 << pick)}) begin
            n_fail++;
            $display("FAIL rr_rsp_%0d: valid/err/mask got %b/%b/%h expected 1/0/%h", k,
                     o_rvalid, o_rerr, o_rmask, 5'(1 << pick));
         end
         up_rsp_ready = 1'b1;
         tick();
         up_rsp_ready = 1'b0;
      end
      dn_rsp_valid = '0;
   endtask

   task automatic test_fifo_full();
      logic [DW-1:0] q[$];
      int lvl = 0;
      int nacc = 0;
      int served = 0;
      bit idle = 1'b1;
      bit exp_rdy, push, pop;
      do_reset(); mode = 1'b0;
      child_en = 5'h1F;
      for (int c = 0; c < 8; c++) begin
         up_cmd_valid = (nacc < 6);
         up_cmd_data  = 16'(16'hC000 + nacc);
         exp_rdy = (lvl < DP);
         n_cmp++;
         if ({o_ready, o_lvl} !== {exp_rdy, 3'(lvl)}) begin
            n_fail++;
            $display("FAIL full_c%0d: ready/level got %b/%0d expected %b/%0d", c, o_ready, o_lvl,
                     exp_rdy, lvl);
         end
         push = up_cmd_valid && exp_rdy;
         pop  = idle && (lvl > 0);
         if (pop) idle = 1'b0;
         if (push) begin q.push_back(up_cmd_data); nacc++; end
         lvl = lvl + int'(push) - int'(pop);
         tick();
      end
      dn_cmd_ready = 5'h1F; dn_rsp_valid = 5'h1F; up_rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 120 && served < 6; cyc++) begin
         up_cmd_valid = (nacc < 6);
         up_cmd_data  = 16'(16'hC000 + nacc);
         if (o_dvalid != '0) begin
            n_cmp++;
            if (o_ddata !== q[served]) begin
               n_fail++; $display("FAIL full_order_%0d: got %h expected %h", served, o_ddata, q[served]);
            end
            served++;
         end
         if (up_cmd_valid && o_ready) begin q.push_back(up_cmd_data); nacc++; end
         tick();
      end
      up_cmd_valid = 1'b0;
      n_cmp++;
      if (served != 6) begin
         n_fail++; $display("FAIL full_served: got %0d commands expected 6", served);
      end
      repeat (4) tick();
      n_cmp++;
      if ({o_busy, o_lvl} !== 4'b0000) begin
         n_fail++; $display("FAIL full_drain: busy/level got %b/%0d expected 0/0", o_busy, o_lvl);
      end
      dn_rsp_valid = '0; up_rsp_ready = 1'b0;
   endtask

   task automatic test_no_target();
      do_reset(); mode = 1'b0;
      child_en = '0; dn_cmd_ready = 5'h1F;
      up_cmd_valid = 1'b1; up_cmd_data = 16'hBEEF;
      tick();
      up_cmd_valid = 1'b0;
      n_cmp++;
      if ({o_dvalid, o_rvalid} !== 6'b0) begin
         n_fail++; $display("FAIL notgt_t1: valid/rsp got %h/%b expected 00/0", o_dvalid, o_rvalid);
      end
      tick();
      n_cmp++;
      if ({o_dvalid, o_rvalid, o_rerr, o_rmask} !== {5'h00, 1'b1, 1'b1, 5'h00}) begin
         n_fail++;
         $display("FAIL notgt_rsp: dvalid/valid/err/mask got %h/%b/%b/%h expected 00/1/1/00",
                  o_dvalid, o_rvalid, o_rerr, o_rmask);
      end
      up_rsp_ready = 1'b1;
      tick();
      up_rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [NC-1:0] en = 5'b10110;
      do_reset(); mode = 1'b1;
      child_en = en; dn_cmd_ready = 5'h1F;
      up_cmd_valid = 1'b1; up_cmd_data = 16'h0001;
      tick();
      up_cmd_valid = 1'b0;
      repeat (2) tick();
      dn_rsp_valid = 5'h1F;
      tick();
      dn_rsp_valid = '0; up_rsp_ready = 1'b1;
      tick();
      up_rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         up_cmd_valid = 1'b1; up_cmd_data = 16'(16'h0100 + k);
         tick();
      end
      up_cmd_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_lvl, o_busy} !== {3'd3, 1'b1}) begin
         n_fail++; $display("FAIL midrst_pre: level/busy got %0d/%b expected 3/1", o_lvl, o_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if1.dn_cmd_valid, if1.up_rsp_valid, if1.up_rsp_err, if1.up_rsp_mask,
           if1.dn_cmd_data, lvl1, busy1} !== '0) begin
         n_fail++; $display("FAIL midrst_outputs: got nonzero outputs, expected all 0");
      end
      tick();
      rst_n = 1'b1;
      tick();
      up_cmd_valid = 1'b1; up_cmd_data = 16'h0200;
      tick();
      up_cmd_valid = 1'b0;
      tick();
      n_cmp++;
      if ({o_dvalid, o_ddata} !== {5'(1 << rr_pick(en, 0)), 16'h0200}) begin
         n_fail++;
         $display("FAIL midrst_rr: valid/data got %h/%h expected %h/0200", o_dvalid, o_ddata,
                  5'(1 << rr_pick(en, 0)));
      end
   endtask

   task automatic test_random(input logic m, input int ncmd);
      logic [NC-1:0] en, tgt, acc, done, nd;
      logic [DW-1:0] data;
      logic          erra;
      int            ptr, pick, hold;
      do_reset(); mode = m;
      ptr = 0;
      for (int n = 0; n < ncmd; n++) begin
         en   = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom);
         data = DW'($urandom);
         if (!m) begin
            tgt = en;
         end else begin
            pick = rr_pick(en, ptr);
            tgt  = (pick < 0) ? '0 : NC'(1 << pick);
            if (pick >= 0) ptr = (pick + 1) % NC;
         end
         child_en = en; up_cmd_valid = 1'b1; up_cmd_data = data;
         n_cmp++;
         if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd_ready_%0d: got 0 expected 1", n);
         end
         tick();
         up_cmd_valid = 1'b0;
         n_cmp++;
         if ({o_dvalid, o_rvalid} !== 6'b0) begin
            n_fail++; $display("FAIL rnd_pop_%0d: valid/rsp got %h/%b expected 00/0", n, o_dvalid, o_rvalid);
         end
         tick();
         acc = '0; done = '0; erra = (tgt == '0);
         for (int cyc = 0; cyc < 200 && tgt != '0; cyc++) begin
            dn_cmd_ready = (cyc > 40) ? '1 : NC'($urandom);
            dn_rsp_valid = (cyc > 40) ? '1 : NC'($urandom & $urandom);
            dn_rsp_err   = NC'($urandom);
            child_en     = NC'($urandom);
            n_cmp++;
            if ({o_dvalid, o_ddata, o_rvalid} !== {tgt & ~acc, data, 1'b0}) begin
               n_fail++;
               $display("FAIL rnd_issue_%0d: valid/data/rsp got %h/%h/%b expected %h/%h/0", n,
                        o_dvalid, o_ddata, o_rvalid, tgt & ~acc, data);
            end
            acc  = acc | (tgt & ~acc & dn_cmd_ready);
            nd   = dn_rsp_valid & tgt & ~done;
            done = done | nd;
            erra = erra | (|(nd & dn_rsp_err));
            tick();
            if (acc == tgt && done == tgt) break;
         end
         dn_rsp_valid = '0;
         hold = $urandom_range(0, 2);
         for (int s = 0; s <= hold; s++) begin
            n_cmp++;
            if ({o_rvalid, o_rerr, o_rmask} !== {1'b1, erra, tgt}) begin
               n_fail++;
               $display("FAIL rnd_rsp_%0d: valid/err/mask got %b/%b/%h expected 1/%b/%h", n,
                        o_rvalid, o_rerr, o_rmask, erra, tgt);
            end
            if (s == hold) up_rsp_ready = 1'b1;
            tick();
         end
         up_rsp_ready = 1'b0;
         n_cmp++;
         if (o_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rnd_hs_%0d: up_rsp_valid got 1 expected 0", n);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mode = 1'b0;
      test_reset();
      test_broadcast();
      test_stall_dup();
      test_round_robin();
      test_fifo_full();
      test_no_target();
      test_reset_mid();
      test_random(1'b0, 30);
      test_random(1'b1, 30);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
